// File: rtl/seq_mult_hs.sv
// seq_mult_hs: shift-and-add multiplier with valid/ready handshakes, signed or unsigned per transaction
module seq_mult_hs #(
  parameter int XLEN = 16
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  input  logic              signed_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [2*XLEN-1:0] product_o
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]        state;
  logic [2*XLEN-1:0] mcand;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_nxt;
  logic [XLEN-1:0]   mplier;
  logic [XLEN-1:0]   mplier_nxt;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic              neg;
  assign ready_o = state == IDLE;
  assign valid_o = state == DONE;
  // operand magnitudes (the most negative value maps to its unsigned magnitude) and next iteration values
  always_comb begin
    a_mag      = (signed_i && a_i[XLEN-1]) ? -a_i : a_i;
    b_mag      = (signed_i && b_i[XLEN-1]) ? -b_i : b_i;
    acc_nxt    = acc + (mplier[0] ? mcand : '0);
    mplier_nxt = mplier >> 1;
  end
  // handshake FSM and datapath; BUSY ends as soon as the remaining multiplier bits are zero
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state     <= IDLE;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      neg       <= 1'b0;
      product_o <= '0;
    end else if (state == IDLE) begin
      if (valid_i) begin
        mcand  <= {{XLEN{1'b0}}, a_mag};
        mplier <= b_mag;
        neg    <= signed_i & (a_i[XLEN-1] ^ b_i[XLEN-1]);
        acc    <= '0;
        state  <= BUSY;
      end
    end else if (state == BUSY) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier_nxt;
      if (mplier_nxt == '0) begin
        state     <= DONE;
        product_o <= neg ? -acc_nxt : acc_nxt;
      end
    end else if (ready_i) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_seq_mult_hs.sv
// tb_seq_mult_hs: directed checks of seq_mult_hs results, latency, backpressure and reset
module tb_seq_mult_hs;
  logic        clk_i = 1'b0;
  logic        resetn_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [15:0] a_i = '0;
  logic [15:0] b_i = '0;
  logic        signed_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] product_o;
  int n_checks = 0;
  int n_fail = 0;

  seq_mult_hs #(.XLEN(16)) dut (
    .clk_i(clk_i), .resetn_i(resetn_i), .valid_i(valid_i), .ready_o(ready_o),
    .a_i(a_i), .b_i(b_i), .signed_i(signed_i), .valid_o(valid_o),
    .ready_i(ready_i), .product_o(product_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic s, input logic [15:0] a, input logic [15:0] b);
    chk("ready_before_accept", 32'(ready_o), 32'd1);
    signed_i = s;
    a_i      = a;
    b_i      = b;
    valid_i  = 1'b1;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    chk("ready_in_busy", 32'(ready_o), 32'd0);
  endtask

  task automatic wait_valid(input string tag, input int n, input logic [31:0] exp);
    int cnt = 0;
    while (valid_o !== 1'b1 && cnt < 40) begin
      @(posedge clk_i);
      #1;
      cnt++;
    end
    chk({tag, "_latency"}, 32'(cnt), 32'(n));
    chk({tag, "_product"}, product_o, exp);
  endtask

  task automatic release_result(input string tag, input logic [31:0] exp);
    ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    ready_i = 1'b0;
    chk({tag, "_valid_drop"}, 32'(valid_o), 32'd0);
    chk({tag, "_ready_back"}, 32'(ready_o), 32'd1);
    chk({tag, "_product_held"}, product_o, exp);
  endtask

  task automatic job(input string tag, input logic s, input logic [15:0] a, input logic [15:0] b,
                     input int n, input logic [31:0] exp);
    accept(s, a, b);
    wait_valid(tag, n, exp);
    release_result(tag, exp);
  endtask

  initial begin
    #2;
    chk("reset_ready", 32'(ready_o), 32'd1);
    chk("reset_valid", 32'(valid_o), 32'd0);
    chk("reset_product", product_o, 32'h0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    resetn_i = 1'b1;
    job("u_full", 1'b0, 16'hFFFF, 16'hFFFF, 16, 32'hFFFE0001);
    job("s_mixed", 1'b1, 16'hFFFD, 16'h0005, 3, 32'hFFFFFFF1);
    job("u_mixed", 1'b0, 16'hFFFD, 16'h0005, 3, 32'h0004FFF1);
    job("s_minmin", 1'b1, 16'h8000, 16'h8000, 16, 32'h40000000);
    job("s_min_one", 1'b1, 16'h8000, 16'h0001, 1, 32'hFFFF8000);
    job("u_zero_b", 1'b0, 16'h1234, 16'h0000, 1, 32'h00000000);
    job("s_zero_a", 1'b1, 16'h0000, 16'hFFFF, 1, 32'h00000000);
    accept(1'b1, 16'hFFFF, 16'h0002);
    wait_valid("bp", 2, 32'hFFFFFFFE);
    for (int i = 0; i < 5; i++) begin
      valid_i  = 1'b1;
      signed_i = i[0];
      a_i      = 16'h1111 * 16'(i + 1);
      b_i      = 16'h0F0F + 16'(i);
      @(posedge clk_i);
      #1;
      chk("bp_valid_hold", 32'(valid_o), 32'd1);
      chk("bp_ready_low", 32'(ready_o), 32'd0);
      chk("bp_product_hold", product_o, 32'hFFFFFFFE);
    end
    valid_i = 1'b0;
    release_result("bp", 32'hFFFFFFFE);
    job("after_bp", 1'b1, 16'h0003, 16'hFFFE, 2, 32'hFFFFFFFA);
    accept(1'b0, 16'hFFFF, 16'hFFFF);
    repeat (5) @(posedge clk_i);
    #1;
    chk("mid_busy_valid", 32'(valid_o), 32'd0);
    resetn_i = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(valid_o), 32'd0);
    chk("rst_mid_product", product_o, 32'h0);
    chk("rst_mid_ready", 32'(ready_o), 32'd1);
    @(posedge clk_i);
    #1;
    resetn_i = 1'b1;
    job("post_rst", 1'b0, 16'd7, 16'd6, 3, 32'h0000002A);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
